// File: rtl/exu_csr_wb_buf.sv
// In-order write-back buffer behind the EXU CSR unit: retires the CSR regfile
// write and the GPR write-back together per entry, and forwards pending CSR writes.
module exu_csr_wb_buf #(
  parameter int DEPTH  = 2,
  parameter int CSR_AW = 32,
  parameter int GPR_AW = 5,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_valid_i,
  output logic              csr_ready_o,
  input  logic              csr_we_i,
  input  logic [CSR_AW-1:0] csr_waddr_i,
  input  logic [DW-1:0]     csr_wdata_i,
  input  logic              reg_we_i,
  input  logic [GPR_AW-1:0] reg_waddr_i,
  input  logic [DW-1:0]     reg_wdata_i,
  input  logic              flush_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_waddr_o,
  output logic [DW-1:0]     csr_wdata_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [GPR_AW-1:0] wb_waddr_o,
  output logic [DW-1:0]     wb_wdata_o,
  input  logic [CSR_AW-1:0] csr_raddr_i,
  output logic              fwd_hit_o,
  output logic [DW-1:0]     fwd_data_o,
  output logic              empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // Entry payload carries no reset; vld_q and count_q decide what is live.
  logic              e_csr_we_q   [DEPTH];
  logic [CSR_AW-1:0] e_csr_addr_q [DEPTH];
  logic [DW-1:0]     e_csr_data_q [DEPTH];
  logic              e_reg_we_q   [DEPTH];
  logic [GPR_AW-1:0] e_reg_addr_q [DEPTH];
  logic [DW-1:0]     e_reg_data_q [DEPTH];

  logic          head_vld;
  logic          push;
  logic          retire;
  logic [PW-1:0] fwd_idx;

  assign csr_ready_o = (count_q != FULL);
  assign empty_o     = (count_q == '0);
  assign head_vld    = (count_q != '0) && !flush_i;
  assign push        = csr_valid_i && csr_ready_o && !flush_i;
  assign retire      = head_vld && (!e_reg_we_q[rd_ptr_q] || wb_ready_i);

  // CSR write and GPR handshake share the same retire cycle.
  assign wb_valid_o  = head_vld && e_reg_we_q[rd_ptr_q];
  assign wb_waddr_o  = wb_valid_o ? e_reg_addr_q[rd_ptr_q] : '0;
  assign wb_wdata_o  = wb_valid_o ? e_reg_data_q[rd_ptr_q] : '0;
  assign csr_we_o    = retire && e_csr_we_q[rd_ptr_q];
  assign csr_waddr_o = csr_we_o ? e_csr_addr_q[rd_ptr_q] : '0;
  assign csr_wdata_o = csr_we_o ? e_csr_data_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      vld_d    = '0;
    end else begin
      if (push) begin
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (retire) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      case ({push, retire})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_idx    = '0;
    if (!flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rd_ptr_q + PW'(i);
        if (vld_q[fwd_idx] && e_csr_we_q[fwd_idx] &&
            (e_csr_addr_q[fwd_idx] == csr_raddr_i)) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = e_csr_data_q[fwd_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      e_csr_we_q[wr_ptr_q]   <= csr_we_i;
      e_csr_addr_q[wr_ptr_q] <= csr_waddr_i;
      e_csr_data_q[wr_ptr_q] <= csr_wdata_i;
      e_reg_we_q[wr_ptr_q]   <= reg_we_i;
      e_reg_addr_q[wr_ptr_q] <= reg_waddr_i;
      e_reg_data_q[wr_ptr_q] <= reg_wdata_i;
    end
  end

endmodule

// File: tb/tb_exu_csr_wb_buf.sv
// Directed cycle-by-cycle vector bench for exu_csr_wb_buf (DEPTH=2), plus an
// asynchronous-reset sequence.
module tb_exu_csr_wb_buf;

  typedef struct packed {
    logic        v;
    logic        cwe;
    logic [31:0] ca;
    logic [31:0] cd;
    logic        rwe;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        fl;
    logic        wbr;
    logic [31:0] rda;
  } in_t;

  typedef struct packed {
    logic        rdy;
    logic        cwe;
    logic [31:0] ca;
    logic [31:0] cd;
    logic        wbv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hit;
    logic [31:0] fd;
    logic        emp;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk, rst;
  logic        csr_valid_i, csr_ready_o, csr_we_i, reg_we_i, flush_i;
  logic [31:0] csr_waddr_i, csr_wdata_i, reg_wdata_i, csr_raddr_i;
  logic [4:0]  reg_waddr_i;
  logic        csr_we_o, wb_valid_o, wb_ready_i, fwd_hit_o, empty_o;
  logic [31:0] csr_waddr_o, csr_wdata_o, wb_wdata_o, fwd_data_o;
  logic [4:0]  wb_waddr_o;

  int tests;
  int fails;
  vec_t vq[$];

  exu_csr_wb_buf #(.DEPTH(2), .CSR_AW(32), .GPR_AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .csr_valid_i(csr_valid_i), .csr_ready_o(csr_ready_o),
    .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .flush_i(flush_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .csr_raddr_i(csr_raddr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t IN(input logic v, input logic cwe, input logic [31:0] ca,
                             input logic [31:0] cd, input logic rwe, input logic [4:0] ra,
                             input logic [31:0] rd, input logic fl, input logic wbr,
                             input logic [31:0] rda);
    IN = '{v:v, cwe:cwe, ca:ca, cd:cd, rwe:rwe, ra:ra, rd:rd, fl:fl, wbr:wbr, rda:rda};
  endfunction

  function automatic in_t IDLE(input logic wbr, input logic [31:0] rda);
    IDLE = IN(0, 0, 0, 0, 0, 0, 0, 0, wbr, rda);
  endfunction

  function automatic out_t OUT(input logic rdy, input logic cwe, input logic [31:0] ca,
                               input logic [31:0] cd, input logic wbv, input logic [4:0] wa,
                               input logic [31:0] wd, input logic hit, input logic [31:0] fd,
                               input logic emp);
    OUT = '{rdy:rdy, cwe:cwe, ca:ca, cd:cd, wbv:wbv, wa:wa, wd:wd, hit:hit, fd:fd, emp:emp};
  endfunction

  function automatic out_t EMPTY_OUT();
    EMPTY_OUT = OUT(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic apply(input in_t x);
    csr_valid_i = x.v;   csr_we_i    = x.cwe; csr_waddr_i = x.ca; csr_wdata_i = x.cd;
    reg_we_i    = x.rwe; reg_waddr_i = x.ra;  reg_wdata_i = x.rd;
    flush_i     = x.fl;  wb_ready_i  = x.wbr; csr_raddr_i = x.rda;
  endtask

  task automatic chk(input string nm, input out_t ex);
    out_t a;
    a = OUT(csr_ready_o, csr_we_o, csr_waddr_o, csr_wdata_o, wb_valid_o,
            wb_waddr_o, wb_wdata_o, fwd_hit_o, fwd_data_o, empty_o);
    tests++;
    if (a !== ex) begin
      fails++;
      $display("FAIL %s: got rdy=%0b cwe=%0b ca=%h cd=%h wbv=%0b wa=%0d wd=%h hit=%0b fd=%h emp=%0b ; want rdy=%0b cwe=%0b ca=%h cd=%h wbv=%0b wa=%0d wd=%h hit=%0b fd=%h emp=%0b",
               nm, a.rdy, a.cwe, a.ca, a.cd, a.wbv, a.wa, a.wd, a.hit, a.fd, a.emp,
               ex.rdy, ex.cwe, ex.ca, ex.cd, ex.wbv, ex.wa, ex.wd, ex.hit, ex.fd, ex.emp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Each record: inputs held for one cycle, outputs expected within that cycle.
    vq.push_back('{i:IDLE(1, 0), o:EMPTY_OUT()});
    // single push, retire next cycle with CSR write and GPR handshake together
    vq.push_back('{i:IN(1,1,32'h300,32'h8,1,5,32'h1800,0,1,0), o:EMPTY_OUT()});
    vq.push_back('{i:IDLE(1, 32'h300), o:OUT(1,1,32'h300,32'h8,1,5,32'h1800,1,32'h8,0)});
    vq.push_back('{i:IDLE(1, 32'h300), o:EMPTY_OUT()});
    // backpressure: third offer refused, head held stable, then in-order drain
    vq.push_back('{i:IN(1,1,32'h301,32'h11,1,1,32'hA1,0,0,0), o:EMPTY_OUT()});
    vq.push_back('{i:IN(1,1,32'h302,32'h22,1,2,32'hA2,0,0,0), o:OUT(1,0,0,0,1,1,32'hA1,0,0,0)});
    vq.push_back('{i:IN(1,1,32'h303,32'h33,1,3,32'hA3,0,0,0), o:OUT(0,0,0,0,1,1,32'hA1,0,0,0)});
    vq.push_back('{i:IDLE(1, 0), o:OUT(0,1,32'h301,32'h11,1,1,32'hA1,0,0,0)});
    vq.push_back('{i:IN(1,1,32'h303,32'h33,1,3,32'hA3,0,1,0), o:OUT(1,1,32'h302,32'h22,1,2,32'hA2,0,0,0)});
    vq.push_back('{i:IDLE(1, 0), o:OUT(1,1,32'h303,32'h33,1,3,32'hA3,0,0,0)});
    vq.push_back('{i:IDLE(1, 0), o:EMPTY_OUT()});
    // reg_we=0 retires despite wb_ready_i=0
    vq.push_back('{i:IN(1,1,32'h340,32'h55,0,7,32'h99,0,0,0), o:EMPTY_OUT()});
    vq.push_back('{i:IDLE(0, 0), o:OUT(1,1,32'h340,32'h55,0,0,0,0,0,0)});
    vq.push_back('{i:IDLE(0, 0), o:EMPTY_OUT()});
    // no write enables: still takes one cycle in the buffer
    vq.push_back('{i:IN(1,0,32'h123,32'h77,0,6,32'h66,0,0,0), o:EMPTY_OUT()});
    vq.push_back('{i:IDLE(0, 32'h123), o:OUT(1,0,0,0,0,0,0,0,0,0)});
    vq.push_back('{i:IDLE(0, 0), o:EMPTY_OUT()});
    // forwarding: youngest of two writes to 0x305 wins
    vq.push_back('{i:IN(1,1,32'h305,32'hA,1,8,32'h1,0,0,32'h305), o:EMPTY_OUT()});
    vq.push_back('{i:IN(1,1,32'h305,32'hB,1,9,32'h2,0,0,32'h305), o:OUT(1,0,0,0,1,8,32'h1,1,32'hA,0)});
    vq.push_back('{i:IDLE(0, 32'h305), o:OUT(0,0,0,0,1,8,32'h1,1,32'hB,0)});
    vq.push_back('{i:IDLE(0, 32'h341), o:OUT(0,0,0,0,1,8,32'h1,0,0,0)});
    // flush with two entries held and an offer pending
    vq.push_back('{i:IN(1,1,32'h305,32'hC,1,10,32'h3,1,1,32'h305), o:OUT(0,0,0,0,0,0,0,0,0,0)});
    vq.push_back('{i:IDLE(1, 32'h305), o:EMPTY_OUT()});

    rst = 1'b0;
    apply(IDLE(1, 0));
    #2;
    chk("in_reset", EMPTY_OUT());
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int k = 0; k < vq.size(); k++) begin
      apply(vq[k].i);
      @(negedge clk);
      chk($sformatf("vec%0d", k), vq[k].o);
      @(posedge clk);
      #1;
    end

    // asynchronous reset with one entry pending and mid-retire
    apply(IN(1,1,32'h3C0,32'h5A,1,4,32'h44,0,0,0));
    @(posedge clk);
    #1 apply(IDLE(1, 0));
    #1 chk("pre_async_rst", OUT(1,1,32'h3C0,32'h5A,1,4,32'h44,0,0,0));
    #1 rst = 1'b0;
    #1 chk("async_rst", EMPTY_OUT());
    @(posedge clk);
    #1 rst = 1'b1;
    apply(IDLE(1, 32'h3C0));
    @(negedge clk);
    chk("post_rst", EMPTY_OUT());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
